// File: rtl/sample_uart_sender.sv
// Pops one 32-bit word from a capture FIFO and sends it as a 5-byte 8N1 UART frame (sync byte + word, LSB byte first).
// Read-to-start-bit latency 3 cycles; a new word is only requested from IDLE, so the UART line throttles the FIFO.
module sample_uart_sender #(
    parameter int unsigned CLK_DIV = 434,
    parameter logic [7:0]  HEADER  = 8'hA5
) (
    input  logic        i_clk,
    input  logic        _mrst,
    input  logic        i_enable,
    input  logic        i_available,
    input  logic [31:0] i_data,
    output logic        o_rdreq,
    output logic        o_tx,
    output logic        o_busy
);
    localparam int unsigned   CW      = $clog2(CLK_DIV);
    localparam logic [CW-1:0] DIV_MAX = CW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LATCH = 2'd2,
        SEND  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic [3:0]    bit_idx_q, bit_idx_d;
    logic [2:0]    byte_idx_q, byte_idx_d;
    logic [31:0]   hold_q, hold_d;

    logic [7:0]    cur_byte;
    logic [9:0]    tx_frame;
    logic          take_word;

    always_ff @(posedge i_clk or negedge _mrst) begin
        if (!_mrst) begin
            state_q    <= IDLE;
            div_cnt_q  <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            hold_q     <= hold_d;
        end
    end

    always_comb begin
        case (byte_idx_q)
            3'd0:    cur_byte = HEADER;
            3'd1:    cur_byte = hold_q[7:0];
            3'd2:    cur_byte = hold_q[15:8];
            3'd3:    cur_byte = hold_q[23:16];
            default: cur_byte = hold_q[31:24];
        endcase
        // Stop bit at index 9, data LSB first, start bit at index 0
        tx_frame = {1'b1, cur_byte, 1'b0};
    end

    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        hold_d     = hold_q;
        o_rdreq    = 1'b0;
        o_busy     = 1'b1;
        o_tx       = 1'b1;
        // Gating with the reset keeps the read request low while reset is held
        take_word  = _mrst & i_enable & i_available;

        case (state_q)
            IDLE: begin
                o_rdreq = take_word;
                o_busy  = take_word;
                if (take_word) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = LATCH;
            end
            LATCH: begin
                hold_d  = i_data;
                state_d = SEND;
            end
            SEND: begin
                o_tx = tx_frame[bit_idx_q];
                if (div_cnt_q == DIV_MAX) begin
                    div_cnt_d = '0;
                    if (bit_idx_q == 4'd9) begin
                        bit_idx_d = '0;
                        if (byte_idx_q == 3'd4) begin
                            byte_idx_d = '0;
                            state_d    = IDLE;
                        end else begin
                            byte_idx_d = byte_idx_q + 3'd1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sample_uart_sender.sv
// Bench for sample_uart_sender: FIFO model plus UART line decoders feed a byte-stream reference built from the pushed words.
// Two instances cover the default-style divider (4) and the minimum divider (2).
module tb_sample_uart_sender;
    localparam int         D1  = 4;
    localparam int         D2  = 2;
    localparam logic [7:0] HDR = 8'hA5;
    localparam int         SP1 = 50 * D1 + 3;

    logic        i_clk;
    logic        rst_n;
    logic        en1, avail1, rd1, tx1, busy1;
    logic [31:0] data1 = '0;
    logic        en2, avail2, rd2, tx2, busy2;
    logic [31:0] data2;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    sample_uart_sender #(.CLK_DIV(D1), .HEADER(HDR)) u_dut1 (
        .i_clk(i_clk), ._mrst(rst_n), .i_enable(en1), .i_available(avail1),
        .i_data(data1), .o_rdreq(rd1), .o_tx(tx1), .o_busy(busy1)
    );

    sample_uart_sender #(.CLK_DIV(D2), .HEADER(HDR)) u_dut2 (
        .i_clk(i_clk), ._mrst(rst_n), .i_enable(en2), .i_available(avail2),
        .i_data(data2), .o_rdreq(rd2), .o_tx(tx2), .o_busy(busy2)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Non-showahead FIFO: q updates one cycle after the read; once the word has been
    // latched the q output is scrambled so a late capture would be exposed.
    logic [31:0] fmem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int rd_age = 10;
    assign avail1 = (wr_ptr != rd_ptr);

    always @(posedge i_clk) begin
        if (rd1 && avail1) begin
            data1  <= fmem[rd_ptr % 64];
            rd_ptr <= rd_ptr + 1;
            rd_age <= 0;
        end else begin
            if (rd_age < 10) rd_age <= rd_age + 1;
            if (rd_age >= 2) data1 <= $urandom;
        end
    end

    logic [7:0] exp_q1[$];
    logic [7:0] rx_q1[$];
    logic [7:0] rx_q2[$];
    int rd_times[$];
    int bad1 = 0, bad2 = 0, bad_rd = 0, rd2_cnt = 0;
    int busy_run1 = 0, last_busy1 = 0, busy_run2 = 0, last_busy2 = 0;

    task automatic push_word(input logic [31:0] w, input bit add_exp);
        fmem[wr_ptr % 64] = w;
        wr_ptr = wr_ptr + 1;
        if (add_exp) begin
            exp_q1.push_back(HDR);
            for (int k = 0; k < 4; k++) exp_q1.push_back(8'((w >> (8 * k)) & 32'hFF));
        end
    endtask

    function automatic logic txv(input bit sel);
        return sel ? tx2 : tx1;
    endfunction

    // Decodes one 10-bit character whose start bit was seen at the current negedge;
    // every bit must hold for exactly div samples.
    task automatic rx_byte(input bit sel, input int div, output logic [7:0] b,
                           output bit good, output bit aborted);
        logic [9:0] bits;
        good = 1'b1;
        aborted = 1'b0;
        bits = '0;
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < div; j++) begin
                if (k != 0 || j != 0) @(negedge i_clk);
                if (!rst_n) aborted = 1'b1;
                if (j == 0) bits[k] = txv(sel);
                else if (txv(sel) !== bits[k]) good = 1'b0;
            end
        end
        if (bits[0] !== 1'b0 || bits[9] !== 1'b1) good = 1'b0;
        b = bits[8:1];
    endtask

    logic [7:0] m1_b, m2_b;
    bit m1_g, m1_a, m2_g, m2_a;

    always begin : mon1
        @(negedge i_clk);
        if (rst_n && tx1 === 1'b0) begin
            rx_byte(1'b0, D1, m1_b, m1_g, m1_a);
            if (!m1_a) begin
                rx_q1.push_back(m1_b);
                if (!m1_g) bad1 <= bad1 + 1;
            end
        end
    end

    always begin : mon2
        @(negedge i_clk);
        if (rst_n && tx2 === 1'b0) begin
            rx_byte(1'b1, D2, m2_b, m2_g, m2_a);
            if (!m2_a) begin
                rx_q2.push_back(m2_b);
                if (!m2_g) bad2 <= bad2 + 1;
            end
        end
    end

    always @(negedge i_clk) begin
        if (rd1) begin
            rd_times.push_back(cyc);
            if (!avail1 || !en1) bad_rd <= bad_rd + 1;
        end
        if (rd2) rd2_cnt <= rd2_cnt + 1;
        if (busy1) busy_run1 <= busy_run1 + 1;
        else begin
            if (busy_run1 != 0) last_busy1 <= busy_run1;
            busy_run1 <= 0;
        end
        if (busy2) busy_run2 <= busy_run2 + 1;
        else begin
            if (busy_run2 != 0) last_busy2 <= busy_run2;
            busy_run2 <= 0;
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_rd(input int n, input int max, input string tag);
        int k = 0;
        while (rd_times.size() < n && k < max) begin
            @(negedge i_clk);
            k++;
        end
        chk({tag, "_rd_seen"}, rd_times.size() >= n, 1'b1);
    endtask

    task automatic wait_quiet(input int max, input string tag);
        int q = 0;
        int k = 0;
        while (q < 20 && k < max) begin
            @(negedge i_clk);
            k++;
            if (!busy1 && !busy2) q++;
            else q = 0;
        end
        chk({tag, "_quiet"}, q >= 20, 1'b1);
    endtask

    task automatic cmp_stream(input string tag);
        int n;
        chk({tag, "_len"}, rx_q1.size(), exp_q1.size());
        n = (rx_q1.size() < exp_q1.size()) ? rx_q1.size() : exp_q1.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s_b%0d", tag, i), rx_q1[i], exp_q1[i]);
        chk({tag, "_bitfmt"}, bad1, 0);
    endtask

    task automatic clear_all();
        rx_q1.delete();
        exp_q1.delete();
        rd_times.delete();
    endtask

    task automatic wait_cyc(input int target);
        do tick(); while (cyc < target);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int viol;
        int target;
        logic [31:0] w;
        logic [7:0] exp2[$];

        rst_n = 1'b0;
        en1 = 1'b0;
        en2 = 1'b0;
        avail2 = 1'b0;
        data2 = 32'h8000_0001;
        repeat (3) tick();

        // Held reset with work pending must keep the outputs quiet
        en1 = 1'b1;
        push_word(32'h1234_5678, 1'b1);
        tick();
        chk("rst_rdreq", rd1, 1'b0);
        chk("rst_tx", tx1, 1'b1);
        chk("rst_busy", busy1, 1'b0);
        chk("rst_tx2", tx2, 1'b1);
        chk("rst_busy2", busy2, 1'b0);
        rst_n = 1'b1;

        // Single word
        wait_rd(1, 10, "f1");
        wait_quiet(400, "f1");
        cmp_stream("f1");
        chk("f1_rdcnt", rd_times.size(), 1);
        chk("f1_busylen", last_busy1, SP1);
        chk("f1_tx_idle", tx1, 1'b1);
        clear_all();

        // Enable low: nothing happens despite a waiting word
        en1 = 1'b0;
        push_word(32'h0000_0000, 1'b1);
        viol = 0;
        repeat (1000) begin
            @(negedge i_clk);
            if (rd1 !== 1'b0 || tx1 !== 1'b1 || busy1 !== 1'b0) viol++;
        end
        chk("idle_viol", viol, 0);
        chk("idle_rdcnt", rd_times.size(), 0);

        // Three words back to back
        push_word(32'hFFFF_FFFF, 1'b1);
        push_word(32'hDEAD_BEEF, 1'b1);
        tick();
        en1 = 1'b1;
        wait_rd(3, 3 * SP1 + 20, "f3");
        wait_quiet(400, "f3");
        cmp_stream("f3");
        chk("f3_rdcnt", rd_times.size(), 3);
        if (rd_times.size() >= 3) begin
            chk("f3_gap1", rd_times[1] - rd_times[0], SP1);
            chk("f3_gap2", rd_times[2] - rd_times[1], SP1);
        end
        repeat (300) @(negedge i_clk);
        chk("f3_no_more", rd_times.size(), 3);
        clear_all();

        // Enable dropped mid-frame: frame completes, second word stays queued
        tick();
        push_word($urandom, 1'b1);
        push_word($urandom, 1'b0);
        wait_rd(1, 10, "ed");
        if (rd_times.size() > 0) begin
            wait_cyc(rd_times[0] + 3 + 60);
        end
        en1 = 1'b0;
        wait_quiet(400, "ed");
        cmp_stream("ed");
        chk("ed_rdcnt", rd_times.size(), 1);
        chk("ed_left", avail1, 1'b1);
        clear_all();

        // Reset mid-byte aborts; the queued word is consumed and discarded
        en1 = 1'b1;
        wait_rd(1, 10, "mr");
        if (rd_times.size() > 0) begin
            wait_cyc(rd_times[0] + 3 + 90);
        end
        chk("mr_busy_before", busy1, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mr_tx_now", tx1, 1'b1);
        chk("mr_busy_now", busy1, 1'b0);
        clear_all();
        w = $urandom;
        push_word(w, 1'b1);
        repeat (50) tick();
        chk("mr_no_rd_in_rst", rd_times.size(), 0);
        rst_n = 1'b1;
        wait_rd(1, 10, "mr2");
        wait_quiet(400, "mr2");
        cmp_stream("mr2");
        chk("mr2_rdcnt", rd_times.size(), 1);
        clear_all();

        // Random words arriving with random gaps
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 400)) tick();
            push_word($urandom, 1'b1);
        end
        wait_rd(6, 6 * SP1 + 50, "rnd");
        wait_quiet(400, "rnd");
        cmp_stream("rnd");
        chk("rnd_rdcnt", rd_times.size(), 6);
        for (int i = 1; i < rd_times.size(); i++)
            chk($sformatf("rnd_gap%0d", i), (rd_times[i] - rd_times[i-1]) >= SP1, 1'b1);
        chk("rd_rules", bad_rd, 0);

        // Minimum divider instance
        exp2.push_back(HDR);
        for (int k = 0; k < 4; k++) exp2.push_back(8'((data2 >> (8 * k)) & 32'hFF));
        en2 = 1'b1;
        avail2 = 1'b1;
        viol = 0;
        while (rd2_cnt == 0 && viol < 10) begin
            @(negedge i_clk);
            viol++;
        end
        tick();
        avail2 = 1'b0;
        wait_quiet(300, "d2");
        chk("d2_rdcnt", rd2_cnt, 1);
        chk("d2_len", rx_q2.size(), 5);
        for (int i = 0; i < 5 && i < rx_q2.size(); i++)
            chk($sformatf("d2_b%0d", i), rx_q2[i], exp2[i]);
        chk("d2_bitfmt", bad2, 0);
        chk("d2_busylen", last_busy2, 50 * D2 + 3);
        chk("d2_tx_idle", tx2, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
